// File: rtl/traffic_ctrl_param.sv
// Three-phase traffic light controller with countdown display and dot-matrix scan.
// Optional pedestrian shortening of green is compiled in with `define PED_BUTTON_EN.
module traffic_ctrl_param #(
  parameter int TICK_DIV = 25000000,
  parameter int SCAN_DIV = 2500,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 5,
  parameter int RED_T    = 10,
  parameter int PED_T    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
  output logic [2:0] light,
  output logic       ped_wait,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {PH_GREEN, PH_YELLOW, PH_RED} phase_e;

  logic [TW-1:0] tick_cnt_q;
  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    row_idx_q;
  phase_e        phase_q, phase_d;
  logic [6:0]    remain_q, remain_d;
  logic [2:0]    light_q;
  logic [7:0]    dot_row_q, dot_col_q;
  logic          sec_tick, scan_wrap;
`ifdef PED_BUTTON_EN
  logic          ped_pend_q;
`endif

  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0: seg7 = 7'h40;
      7'd1: seg7 = 7'h79;
      7'd2: seg7 = 7'h24;
      7'd3: seg7 = 7'h30;
      7'd4: seg7 = 7'h19;
      7'd5: seg7 = 7'h12;
      7'd6: seg7 = 7'h02;
      7'd7: seg7 = 7'h78;
      7'd8: seg7 = 7'h00;
      7'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] bitmap(input phase_e ph, input logic [2:0] r);
    logic [63:0] img;
    case (ph)
      PH_GREEN:  img = 64'h0C0C197E98182848;
      PH_YELLOW: img = 64'h00243CBDFF3C3C00;
      PH_RED:    img = 64'h18183C3C5A181824;
      default:   img = 64'h0;
    endcase
    // Row 0 sits in the most significant byte.
    bitmap = img[8*(7-r) +: 8];
  endfunction

  function automatic logic [2:0] light_of(input phase_e ph);
    case (ph)
      PH_YELLOW: light_of = 3'b010;
      PH_RED:    light_of = 3'b100;
      default:   light_of = 3'b001;
    endcase
  endfunction

  assign sec_tick  = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    if (sec_tick) begin
      if (remain_q == 7'd1) begin
        case (phase_q)
          PH_GREEN:  begin phase_d = PH_YELLOW; remain_d = 7'(YELLOW_T); end
          PH_YELLOW: begin phase_d = PH_RED;    remain_d = 7'(RED_T);    end
          default:   begin phase_d = PH_GREEN;  remain_d = 7'(GREEN_T);  end
        endcase
      end else begin
`ifdef PED_BUTTON_EN
        if (ped_pend_q && (remain_q > 7'(PED_T)))
          remain_d = 7'(PED_T);
        else
`endif
          remain_d = remain_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      phase_q    <= PH_GREEN;
      remain_q   <= 7'(GREEN_T);
      light_q    <= 3'b001;
    end else begin
      tick_cnt_q <= sec_tick ? '0 : tick_cnt_q + TW'(1);
      phase_q    <= phase_d;
      remain_q   <= remain_d;
      light_q    <= light_of(phase_d);
    end
  end

  // The bitmap follows the phase held before this edge, so a phase change lands on the next row.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      row_idx_q  <= 3'd0;
      dot_row_q  <= 8'hFF;
      dot_col_q  <= 8'h00;
    end else if (scan_wrap) begin
      scan_cnt_q <= '0;
      row_idx_q  <= row_idx_q + 3'd1;
      dot_row_q  <= ~(8'h80 >> row_idx_q);
      dot_col_q  <= bitmap(phase_q, row_idx_q);
    end else begin
      scan_cnt_q <= scan_cnt_q + SW'(1);
    end
  end

`ifdef PED_BUTTON_EN
  // A request is only taken while green and is dropped on the edge that leaves green.
  always_ff @(posedge clock) begin
    if (!reset)
      ped_pend_q <= 1'b0;
    else
      ped_pend_q <= (phase_d == PH_GREEN) &&
                    (ped_pend_q || ((phase_q == PH_GREEN) && ped_req));
  end
  assign ped_wait = ped_pend_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_wait       = 1'b0;
`endif

  assign light    = light_q;
  assign dot_row  = dot_row_q;
  assign dot_col  = dot_col_q;
  assign seg_tens = (remain_q < 7'd10) ? 7'h7F : seg7(remain_q / 7'd10);
  assign seg_ones = seg7(remain_q % 7'd10);

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param with small dividers; a second instance uses GREEN_T=99.
module tb_traffic_ctrl_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, ped_req;
  logic [2:0] light, light2;
  logic       ped_wait, ped_wait2;
  logic [7:0] dot_row, dot_col, dot_row2, dot_col2;
  logic [6:0] seg_tens, seg_ones, seg_tens2, seg_ones2;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;
  int r;

`ifdef PED_BUTTON_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic [7:0] ROWSEL [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] GRN    [8] = '{8'h0C, 8'h0C, 8'h19, 8'h7E, 8'h98, 8'h18, 8'h28, 8'h48};
  logic [7:0] YEL    [8] = '{8'h00, 8'h24, 8'h3C, 8'hBD, 8'hFF, 8'h3C, 8'h3C, 8'h00};
  logic [6:0] SEG    [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  traffic_ctrl_param #(.TICK_DIV(4), .SCAN_DIV(2), .GREEN_T(3), .YELLOW_T(2),
                       .RED_T(4), .PED_T(1)) dut (
    .clock(clock), .reset(reset), .ped_req(ped_req), .light(light),
    .ped_wait(ped_wait), .dot_row(dot_row), .dot_col(dot_col),
    .seg_tens(seg_tens), .seg_ones(seg_ones));

  traffic_ctrl_param #(.TICK_DIV(4), .SCAN_DIV(2), .GREEN_T(99), .YELLOW_T(2),
                       .RED_T(4), .PED_T(1)) dut99 (
    .clock(clock), .reset(reset), .ped_req(1'b0), .light(light2),
    .ped_wait(ped_wait2), .dot_row(dot_row2), .dot_col(dot_col2),
    .seg_tens(seg_tens2), .seg_ones(seg_ones2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    cyc   = 0;
  endtask

  // Expected light / countdown k edges after reset release (GREEN 3, YELLOW 2, RED 4 ticks of 4 cycles).
  function automatic logic [2:0] exp_light(input int k);
    if (k < 12)      exp_light = 3'b001;
    else if (k < 20) exp_light = 3'b010;
    else if (k < 36) exp_light = 3'b100;
    else             exp_light = 3'b001;
  endfunction

  function automatic int exp_rem(input int k);
    if (k < 12)      exp_rem = 3 - k / 4;
    else if (k < 20) exp_rem = 2 - (k - 12) / 4;
    else if (k < 36) exp_rem = 4 - (k - 20) / 4;
    else             exp_rem = 3 - (k - 36) / 4;
  endfunction

  initial begin
    reset   = 1'b0;
    ped_req = 1'b0;
    step();
    step();
    chk("rst_light",    light,     8'h01);
    chk("rst_ped_wait", ped_wait,  8'h00);
    chk("rst_dot_row",  dot_row,   8'hFF);
    chk("rst_dot_col",  dot_col,   8'h00);
    chk("rst_seg_ones", seg_ones,  SEG[3]);
    chk("rst_seg_tens", seg_tens,  8'h7F);
    chk("rst99_light",  light2,    8'h01);
    chk("rst99_pw",     ped_wait2, 8'h00);
    chk("rst99_col",    dot_col2,  8'h00);
    chk("g99_tens",     seg_tens2, SEG[9]);
    chk("g99_ones",     seg_ones2, SEG[9]);

    // Full cycle of phases plus dot-matrix scan across the GREEN->YELLOW change.
    reset = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("cyc_light", light, exp_light(cyc));
      chk("cyc_ones", seg_ones, SEG[exp_rem(cyc)]);
      if ((cyc % 2 == 0) && (cyc <= 18)) begin
        r = (cyc / 2 - 1) % 8;
        chk("scan_row", dot_row, ROWSEL[r]);
        chk("scan_col", dot_col, (cyc <= 12) ? GRN[r] : YEL[r]);
      end
      if ((cyc % 2 == 0) && (cyc <= 16)) begin
        r = cyc / 2 - 1;
        chk("g99_row", dot_row2, ROWSEL[r]);
        chk("g99_col", dot_col2, GRN[r]);
      end
    end
    run_to(356);
    chk("g99_10_tens", seg_tens2, SEG[1]);
    chk("g99_10_ones", seg_ones2, SEG[0]);
    run_to(360);
    chk("g99_9_tens", seg_tens2, 8'h7F);
    chk("g99_9_ones", seg_ones2, SEG[9]);

    // Pedestrian request at remain=3 in GREEN.
    do_reset();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ped_wait_set", ped_wait, 8'(PED_EN));
    run_to(4);
    chk("ped_short", seg_ones, PED_EN ? SEG[1] : SEG[2]);
    run_to(7);
    chk("ped_g_light", light, 8'h01);
    chk("ped_g_wait", ped_wait, 8'(PED_EN));
    chk("ped_g_ones", seg_ones, PED_EN ? SEG[1] : SEG[2]);
    run_to(8);
    chk("ped_y_light", light, PED_EN ? 8'h02 : 8'h01);
    chk("ped_y_wait", ped_wait, 8'h00);
    chk("ped_y_ones", seg_ones, PED_EN ? SEG[2] : SEG[1]);
    run_to(12);
    chk("ped_y2_light", light, 8'h02);

    // Request coincident with a sec_tick, then a request during RED.
    do_reset();
    run_to(3);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("coin_wait", ped_wait, 8'(PED_EN));
    chk("coin_ones", seg_ones, SEG[2]);
    run_to(12);
    chk("coin_y_light", light, 8'h02);
    chk("coin_y_wait", ped_wait, 8'h00);
    run_to(21);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("red_wait", ped_wait, 8'h00);
    chk("red_light", light, 8'h04);
    run_to(35);
    chk("red_end_light", light, 8'h04);
    chk("red_end_ones", seg_ones, SEG[1]);
    run_to(36);
    chk("red_g_light", light, 8'h01);
    chk("red_g_ones", seg_ones, SEG[3]);

    // Reset asserted in RED with remain=2, mid-scan.
    do_reset();
    run_to(29);
    chk("mid_light", light, 8'h04);
    chk("mid_ones", seg_ones, SEG[2]);
    reset = 1'b0;
    step();
    chk("mrst_light", light, 8'h01);
    chk("mrst_ones", seg_ones, SEG[3]);
    chk("mrst_row", dot_row, 8'hFF);
    chk("mrst_col", dot_col, 8'h00);
    chk("mrst_wait", ped_wait, 8'h00);
    reset = 1'b1;
    cyc   = 0;
    run_to(3);
    chk("rel_ones3", seg_ones, SEG[3]);
    run_to(4);
    chk("rel_ones4", seg_ones, SEG[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_param.md
TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000; clock cycles per one-second tick (>=2).
REQ-002 SHALL have parameter SCAN_DIV, default 2500; clock cycles per dot-matrix row advance (>=2).
REQ-003 SHALL have parameters GREEN_T 15, YELLOW_T 5, RED_T 10; phase durations in seconds, each 1..99.
REQ-004 SHALL have parameter PED_T, default 3; seconds of green remaining after a pedestrian request, 1..GREEN_T.
REQ-005 SHALL have port clock, input, 1, single clock for all logic.
REQ-006 SHALL have port reset, input, 1; synchronous, active-low reset.
REQ-007 SHALL have port ped_req, input, 1; pedestrian request, level-sampled on clock.
REQ-008 SHALL have port light, output, 3; one-hot {red,yellow,green}, registered.
REQ-009 SHALL have port ped_wait, output, 1; pedestrian request pending, registered.
REQ-010 SHALL have port dot_row, output, 8; active-low row select, registered.
REQ-011 SHALL have port dot_col, output, 8; active-high column data, registered.
REQ-012 SHALL have ports seg_tens and seg_ones, output, 7 each; active-low 7-segment digits {g..a}, decoded combinationally from the registered countdown.

Function
REQ-013 SHALL count tick_cnt 0..TICK_DIV-1 and assert an internal sec_tick for one cycle when tick_cnt==TICK_DIV-1, then wrap to 0.
REQ-014 SHALL implement FSM GREEN->YELLOW->RED->GREEN; light = 001/010/100 respectively.
REQ-015 SHALL hold a 7-bit binary countdown remain; on phase entry load that phase's duration; phase lasts exactly DUR sec_ticks.
REQ-016 On sec_tick with remain==1, SHALL advance phase and load the next duration in the same cycle; otherwise decrement by 1.
REQ-017 SHALL display remain as two BCD digits (tens = remain/10, ones = remain%10); tens digit blanked (7'h7F) when remain<10.
REQ-018 SHALL count scan_cnt 0..SCAN_DIV-1; on wrap, increment 3-bit row_idx (7 wraps to 0) and register dot_row = ~(8'h80>>row_idx) and dot_col = bitmap[phase][row_idx] for the pre-increment row_idx.
REQ-019 Bitmaps rows 0..7 (hex) SHALL be GREEN 0C 0C 19 7E 98 18 28 48; YELLOW 00 24 3C BD FF 3C 3C 00; RED 18 18 3C 3C 5A 18 18 24.
REQ-020 Phase change mid-scan SHALL take effect on the next row update; no row is skipped or repeated.
REQ-021 ped_req sampled high while phase==GREEN SHALL set ped_pend (ped_wait=1 next cycle); ped_req in YELLOW/RED SHALL be ignored.
REQ-022 On sec_tick with ped_pend=1 and remain>PED_T, remain SHALL load PED_T (precedence over decrement); if remain<=PED_T, normal countdown applies.
REQ-023 ped_pend SHALL clear on the cycle the FSM leaves GREEN; repeated requests while pending have no further effect.
REQ-024 ped_req and sec_tick in the same cycle: the request SHALL be latched; shortening applies at the following sec_tick.

Reset
REQ-025 With reset==0 at a clock edge, SHALL set phase GREEN, remain=GREEN_T, tick_cnt=0, scan_cnt=0, row_idx=0, ped_pend=0, light=001, ped_wait=0, dot_row=8'hFF, dot_col=8'h00.
REQ-026 Reset mid-phase or mid-scan SHALL abandon all state; first sec_tick occurs TICK_DIV cycles after reset release.

Configuration
REQ-027 With macro PED_BUTTON_EN defined, SHALL implement REQ-021..REQ-024.
REQ-028 Without PED_BUTTON_EN, ped_req SHALL be ignored, ped_wait tied 0, no pedestrian logic synthesised; ports unchanged.

Verification (TICK_DIV=4, SCAN_DIV=2, GREEN_T=3, YELLOW_T=2, RED_T=4, PED_T=1)
REQ-029 Reset then run 40 cycles -> light 001 for 12 cycles (remain 3,2,1), 010 for 8, 100 for 16, then 001; seg_ones tracks remain.
REQ-030 Scan 16 cycles in GREEN -> dot_row steps 7F,BF,DF,EF,F7,FB,FD,FE with dot_col 0C,0C,19,7E,98,18,28,48.
REQ-031 PED_BUTTON_EN, pulse ped_req at remain=3 in GREEN -> ped_wait=1 next cycle; next sec_tick remain=1; YELLOW one tick later; ped_wait=0.
REQ-032 ped_req during RED -> ped_wait stays 0, RED lasts full 4 ticks; without PED_BUTTON_EN any ped_req -> timing identical to REQ-029.
REQ-033 GREEN_T=99 -> seg_tens=0010000, seg_ones=0010000 at entry; at remain=9 seg_tens=1111111.
REQ-034 Assert reset during RED, remain=2 -> next edge light=001, remain=3, dot_row=FF, ped_wait=0.
